// File: rtl/lwc_arbiter.sv
// lwc_arbiter: lets two clients share one LWC (Ascon) core.
//
// Each grant covers one whole message. Grants alternate round-robin between
// the two clients. A grant ends on the core's last DO word handshake. While a
// client holds the grant, its PDI/SDI/DO streams are wired straight through to
// the core with no added latency. The other client sees all-zero outputs.
//
// Optional feature, enabled by defining LWC_ARB_WDT_EN:
//   A stall watchdog. If a grant makes no handshake for WDT_CYCLES cycles, the
//   grant is dropped. The arbiter then pulses wdt_abort high and core_rst low
//   for one cycle.

module lwc_arbiter #(
  parameter int unsigned W          = 32,
  parameter int unsigned WDT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,

  // client 0
  input  logic [W-1:0] c0_pdi_data,
  input  logic         c0_pdi_valid,
  output logic         c0_pdi_ready,
  input  logic [W-1:0] c0_sdi_data,
  input  logic         c0_sdi_valid,
  output logic         c0_sdi_ready,
  output logic [W-1:0] c0_do_data,
  output logic         c0_do_valid,
  output logic         c0_do_last,
  input  logic         c0_do_ready,

  // client 1
  input  logic [W-1:0] c1_pdi_data,
  input  logic         c1_pdi_valid,
  output logic         c1_pdi_ready,
  input  logic [W-1:0] c1_sdi_data,
  input  logic         c1_sdi_valid,
  output logic         c1_sdi_ready,
  output logic [W-1:0] c1_do_data,
  output logic         c1_do_valid,
  output logic         c1_do_last,
  input  logic         c1_do_ready,

  // shared core
  output logic [W-1:0] core_pdi_data,
  output logic         core_pdi_valid,
  input  logic         core_pdi_ready,
  output logic [W-1:0] core_sdi_data,
  output logic         core_sdi_valid,
  input  logic         core_sdi_ready,
  input  logic [W-1:0] core_do_data,
  input  logic         core_do_valid,
  input  logic         core_do_last,
  output logic         core_do_ready,

  // status
  output logic         busy,
  output logic         owner
`ifdef LWC_ARB_WDT_EN
  ,
  output logic         wdt_abort,
  output logic         core_rst
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_served_q, last_served_d;

  logic   req0, req1;
  logic   msg_done;

  assign req0 = c0_pdi_valid | c0_sdi_valid;
  assign req1 = c1_pdi_valid | c1_sdi_valid;

`ifdef LWC_ARB_WDT_EN
  localparam int unsigned CNT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             any_hs;
  logic             wdt_fire;
  logic             wdt_abort_q;
  logic             core_rst_q;
`else
  // The stall limit only matters when the watchdog is built in.
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = ^WDT_CYCLES;
`endif

  // State, grant owner and round-robin history registers.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments. This way every
    // register samples the values from before the edge, whatever order the
    // blocks are evaluated in.
    if (!rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
    end
  end

  // Next-state arbitration and combinational stream forwarding for the owner.
  always_comb begin
    // NOTE: every signal written here gets a default first. Any path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_d        = state_q;
    owner_d        = owner_q;
    last_served_d  = last_served_q;
    msg_done       = 1'b0;

    core_pdi_data  = '0;
    core_pdi_valid = 1'b0;
    core_sdi_data  = '0;
    core_sdi_valid = 1'b0;
    core_do_ready  = 1'b0;

    c0_pdi_ready   = 1'b0;
    c0_sdi_ready   = 1'b0;
    c0_do_data     = '0;
    c0_do_valid    = 1'b0;
    c0_do_last     = 1'b0;

    c1_pdi_ready   = 1'b0;
    c1_sdi_ready   = 1'b0;
    c1_do_data     = '0;
    c1_do_valid    = 1'b0;
    c1_do_last     = 1'b0;

`ifdef LWC_ARB_WDT_EN
    stall_cnt_d    = '0;
    any_hs         = 1'b0;
    wdt_fire       = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Everything stays quiet. The grant is decided now and takes effect
        // next cycle.
        if (req0 | req1) begin
          state_d = ST_BUSY;
          if (req0 && req1) begin
            owner_d = ~last_served_q;
          end else begin
            owner_d = req1;
          end
        end
      end

      ST_BUSY: begin
        // Core-facing side follows the owner's streams.
        core_pdi_data  = owner_q ? c1_pdi_data  : c0_pdi_data;
        core_pdi_valid = owner_q ? c1_pdi_valid : c0_pdi_valid;
        core_sdi_data  = owner_q ? c1_sdi_data  : c0_sdi_data;
        core_sdi_valid = owner_q ? c1_sdi_valid : c0_sdi_valid;
        core_do_ready  = owner_q ? c1_do_ready  : c0_do_ready;

        // Client-facing side: only the owner sees the core. The other client
        // stays at zero.
        if (owner_q) begin
          c1_pdi_ready = core_pdi_ready;
          c1_sdi_ready = core_sdi_ready;
          c1_do_data   = core_do_data;
          c1_do_valid  = core_do_valid;
          c1_do_last   = core_do_last;
        end else begin
          c0_pdi_ready = core_pdi_ready;
          c0_sdi_ready = core_sdi_ready;
          c0_do_data   = core_do_data;
          c0_do_valid  = core_do_valid;
          c0_do_last   = core_do_last;
        end

        // Only a real handshake of the last DO word ends the message. A stray
        // last flag without valid is ignored.
        msg_done = core_do_valid & core_do_ready & core_do_last;
        if (msg_done) begin
          state_d       = ST_IDLE;
          last_served_d = owner_q;
        end

`ifdef LWC_ARB_WDT_EN
        // Any handshake on any stream counts as progress.
        any_hs = (core_pdi_valid & core_pdi_ready)
               | (core_sdi_valid & core_sdi_ready)
               | (core_do_valid  & core_do_ready);
        if (any_hs) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q == WDT_LAST) begin
          wdt_fire      = 1'b1;
          stall_cnt_d   = '0;
          state_d       = ST_IDLE;
          last_served_d = owner_q;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
`endif
      end
    endcase
  end

`ifdef LWC_ARB_WDT_EN
  // Stall counter and the one-cycle abort / core reset pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      wdt_abort_q <= 1'b0;
      core_rst_q  <= 1'b1;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wdt_abort_q <= wdt_fire;
      core_rst_q  <= ~wdt_fire;
    end
  end

  assign wdt_abort = wdt_abort_q;
  assign core_rst  = core_rst_q;
`endif

  assign busy  = (state_q == ST_BUSY);
  assign owner = owner_q;

endmodule
